// File: rtl/traffic_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_sensor_cond
//  Purpose  : Synchronizes, debounces and holds the two street detectors,
//             producing occupancy flags Ta/Tb and saturating vehicle counts.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_sensor_cond #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sa_raw,
    input  logic             sb_raw,
    input  logic             clr_cnt,
    output logic             Ta,
    output logic             Tb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int c_DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARM  = 2'd1;
    localparam logic [1:0] c_OCC  = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    logic [1:0]       w_raw;
    logic [1:0]       w_flag;
    logic [CNT_W-1:0] w_cnt [2];

    assign w_raw = {sb_raw, sa_raw};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            logic                r_sync1;
            logic                r_sync2;
            logic [1:0]          r_state;
            logic [c_DEB_W-1:0]  r_deb;
            logic [c_HOLD_W-1:0] r_hold;
            logic                r_flag;
            logic [CNT_W-1:0]    r_cnt;
            logic                w_inc;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_raw[g];
                    r_sync2 <= r_sync1;
                end
            end

            // A fresh vehicle is an OCC entry from IDLE or ARM, never from HOLD.
            assign w_inc = r_sync2 &
                           (((r_state == c_IDLE) && (DEB_CYCLES == 1)) ||
                            ((r_state == c_ARM) && (r_deb == c_DEB_LAST)));

            // The flag is set alongside the state so it rises on the OCC entry edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= c_IDLE;
                    r_deb   <= '0;
                    r_hold  <= '0;
                    r_flag  <= 1'b0;
                end else begin
                    case (r_state)
                        c_IDLE: begin
                            r_deb <= '0;
                            if (r_sync2) begin
                                if (DEB_CYCLES == 1) begin
                                    r_state <= c_OCC;
                                    r_flag  <= 1'b1;
                                end else begin
                                    r_state <= c_ARM;
                                    r_deb   <= c_DEB_W'(1);
                                end
                            end
                        end
                        c_ARM: begin
                            if (!r_sync2) begin
                                r_state <= c_IDLE;
                                r_deb   <= '0;
                            end else if (r_deb == c_DEB_LAST) begin
                                r_state <= c_OCC;
                                r_flag  <= 1'b1;
                            end else begin
                                r_deb <= r_deb + c_DEB_W'(1);
                            end
                        end
                        c_OCC: begin
                            if (!r_sync2) begin
                                r_state <= c_HOLD;
                                r_hold  <= '0;
                            end
                        end
                        default: begin
                            // Leaves on the sample where the count already
                            // reads HOLD_CYCLES-1: HOLD_CYCLES cycles in HOLD.
                            if (r_sync2) begin
                                r_state <= c_OCC;
                            end else if (r_hold == c_HOLD_LAST) begin
                                r_state <= c_IDLE;
                                r_flag  <= 1'b0;
                                r_deb   <= '0;
                            end else begin
                                r_hold <= r_hold + c_HOLD_W'(1);
                            end
                        end
                    endcase
                end
            end

            // A clear coinciding with a new vehicle keeps that vehicle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (clr_cnt) begin
                    r_cnt <= w_inc ? CNT_W'(1) : '0;
                end else if (w_inc && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_flag[g] = r_flag;
            assign w_cnt[g]  = r_cnt;
        end
    endgenerate

    assign Ta    = w_flag[0];
    assign Tb    = w_flag[1];
    assign cnt_a = w_cnt[0];
    assign cnt_b = w_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_sensor_cond
//  Purpose  : Directed self-checking bench, DEB_CYCLES=4, HOLD_CYCLES=8;
//             a second instance with CNT_W=2 shares the stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_sensor_cond;

    logic       clk;
    logic       rst;
    logic       sa_raw;
    logic       sb_raw;
    logic       clr_cnt;
    logic       Ta, Tb, Ta2, Tb2;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_a2, cnt_b2;

    int nChecks = 0;
    int nPass   = 0;

    traffic_sensor_cond #(.DEB_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .sa_raw(sa_raw), .sb_raw(sb_raw), .clr_cnt(clr_cnt),
        .Ta(Ta), .Tb(Tb), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    traffic_sensor_cond #(.DEB_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .sa_raw(sa_raw), .sb_raw(sb_raw), .clr_cnt(clr_cnt),
        .Ta(Ta2), .Tb(Tb2), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vehicleA();
        sa_raw = 1'b1;
        tick(6);
        sa_raw = 1'b0;
        tick(12);
    endtask

    logic seen;

    initial begin
        rst = 1'b1; sa_raw = 1'b0; sb_raw = 1'b0; clr_cnt = 1'b0;
        tick(2);
        check("reset_Ta", 32'(Ta), 0);
        check("reset_Tb", 32'(Tb), 0);
        check("reset_cnt_a", 32'(cnt_a), 0);
        check("reset_cnt_b", 32'(cnt_b), 0);
        rst = 1'b0;
        tick(2);

        // 3-cycle pulse is rejected
        sa_raw = 1'b1;
        tick(3);
        sa_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen |= Ta;
        end
        check("glitch3_Ta_never", 32'(seen), 0);
        check("glitch3_cnt_a", 32'(cnt_a), 0);

        // 4-cycle pulse: OCC at edge 5, HOLD at edge 6, low at edge 14
        sa_raw = 1'b1;
        tick(4);
        sa_raw = 1'b0;
        tick(1);
        check("pulse4_Ta_edge4", 32'(Ta), 0);
        tick(1);
        check("pulse4_Ta_edge5", 32'(Ta), 1);
        check("pulse4_cnt_a", 32'(cnt_a), 1);
        tick(8);
        check("pulse4_Ta_edge13", 32'(Ta), 1);
        tick(1);
        check("pulse4_Ta_edge14", 32'(Ta), 0);
        check("pulse4_cnt_sat", 32'(cnt_a2), 1);
        tick(3);

        // bridge a 5-cycle drop
        sa_raw = 1'b1;
        tick(6);
        check("bridge_rise_Ta", 32'(Ta), 1);
        check("bridge_rise_cnt_a", 32'(cnt_a), 2);
        tick(2);
        sa_raw = 1'b0;
        seen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            seen &= Ta;
        end
        sa_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen &= Ta;
        end
        check("bridge_Ta_always_high", 32'(seen), 1);
        check("bridge_cnt_a", 32'(cnt_a), 2);
        sa_raw = 1'b0;
        tick(10);
        check("final_drop_Ta_edge9", 32'(Ta), 1);
        tick(1);
        check("final_drop_Ta_edge10", 32'(Ta), 0);

        // asynchronous reset in the middle of HOLD
        sa_raw = 1'b1;
        tick(8);
        sa_raw = 1'b0;
        tick(4);
        check("prereset_Ta_hold", 32'(Ta), 1);
        check("prereset_cnt_a", 32'(cnt_a), 3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_Ta", 32'(Ta), 0);
        check("async_rst_cnt_a", 32'(cnt_a), 0);
        sa_raw = 1'b1;
        tick(2);
        check("rst_held_Ta", 32'(Ta), 0);
        rst = 1'b0;
        tick(5);
        check("post_rst_Ta_edge4", 32'(Ta), 0);
        tick(1);
        check("post_rst_Ta_edge5", 32'(Ta), 1);
        check("post_rst_cnt_a", 32'(cnt_a), 1);
        sa_raw = 1'b0;
        tick(12);
        check("post_rst_idle_Ta", 32'(Ta), 0);

        // saturation on the 2-bit instance
        for (int i = 0; i < 4; i++) vehicleA();
        check("sat_cnt_a2", 32'(cnt_a2), 3);
        check("nosat_cnt_a", 32'(cnt_a), 5);

        // clear on the same edge as an OCC entry keeps that vehicle
        sa_raw = 1'b1;
        tick(5);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        check("clr_inc_Ta", 32'(Ta), 1);
        check("clr_inc_cnt_a2", 32'(cnt_a2), 1);
        check("clr_inc_cnt_a", 32'(cnt_a), 1);
        sa_raw = 1'b0;
        tick(12);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        check("clr_only_cnt_a2", 32'(cnt_a2), 0);
        check("clr_only_cnt_a", 32'(cnt_a), 0);
        tick(2);

        // independence: B glitches while A debounces, then B occupies
        sa_raw = 1'b1;
        sb_raw = 1'b1;
        tick(3);
        sb_raw = 1'b0;
        tick(3);
        check("indep_Ta", 32'(Ta), 1);
        check("indep_Tb_glitch", 32'(Tb), 0);
        check("indep_cnt_a", 32'(cnt_a), 1);
        check("indep_cnt_b_glitch", 32'(cnt_b), 0);
        sb_raw = 1'b1;
        tick(5);
        check("indep_Tb_edge4", 32'(Tb), 0);
        tick(1);
        check("indep_Tb_edge5", 32'(Tb), 1);
        check("indep_cnt_b", 32'(cnt_b), 1);
        sa_raw = 1'b0;
        tick(11);
        check("indep_Ta_released", 32'(Ta), 0);
        check("indep_Tb_still", 32'(Tb), 1);
        sb_raw = 1'b0;
        tick(10);
        check("indep_Tb_edge9", 32'(Tb), 1);
        tick(1);
        check("indep_Tb_edge10", 32'(Tb), 0);
        check("indep_cnt_b_final", 32'(cnt_b), 1);
        check("indep_cnt_b2_final", 32'(cnt_b2), 1);
        check("indep_cnt_a_final", 32'(cnt_a), 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
